rr_grant_decoder: RTL and testbench

RR_GRANT_DECODER -- requirements
Module: rr_grant_decoder

---
 rtl/rr_grant_decoder.sv | 120 ++++++++++++
 tb/tb_rr_grant_decoder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rr_grant_decoder.sv
// rtl/rr_grant_decoder.sv - round-robin grant register fed by an external priority coder
// Holds a one-hot grant for at most HOLD_MAX cycles and advances the priority pointer on release.
module rr_grant_decoder #(
    parameter int REQCNT   = 3,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int HOLD_MAX = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [REQCNT-1:0]   req_i,
    input  logic [REQWIDTH-1:0] num_i,
    output logic [REQWIDTH-1:0] prior_o,
    output logic [REQCNT-1:0]   gnt_o,
    output logic                gnt_valid_o,
    output logic [REQWIDTH-1:0] gnt_num_o,
    output logic                timeout_o,
    output logic                err_o
);

    localparam int CNTW = $clog2(HOLD_MAX + 1);
    localparam logic [CNTW-1:0]     CNT_LAST = CNTW'(HOLD_MAX - 1);
    localparam logic [REQWIDTH-1:0] IDX_LAST = REQWIDTH'(REQCNT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [REQCNT-1:0]   gnt_q, gnt_d;
    logic [REQWIDTH-1:0] gnt_num_q, gnt_num_d;
    logic [REQWIDTH-1:0] prior_q, prior_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic                err_q, err_d;

    logic                num_ok;
    logic                holder_req;
    logic [REQWIDTH-1:0] prior_next;

    // Index is qualified by an explicit compare so an out-of-range num_i never selects a bit.
    always_comb begin
        num_ok = 1'b0;
        for (int i = 0; i < REQCNT; i++) begin
            if (num_i == REQWIDTH'(i)) begin
                num_ok = req_i[i];
            end
        end
    end

    assign holder_req = |(req_i & gnt_q);
    assign prior_next = (gnt_num_q == IDX_LAST) ? '0 : gnt_num_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_num_d = gnt_num_q;
        prior_d   = prior_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    if (num_ok) begin
                        state_d   = GRANT;
                        gnt_d     = REQCNT'(1) << num_i;
                        gnt_num_d = num_i;
                        cnt_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                if (!holder_req || cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    prior_d   = prior_next;
                    cnt_d     = '0;
                    timeout_d = holder_req;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_num_q <= '0;
            prior_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_num_q <= gnt_num_d;
            prior_q   <= prior_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign prior_o     = prior_q;
    assign gnt_o       = gnt_q;
    assign gnt_valid_o = (state_q == GRANT);
    assign gnt_num_o   = gnt_num_q;
    assign timeout_o   = timeout_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_rr_grant_decoder.sv
// tb/tb_rr_grant_decoder.sv - directed self-checking bench for rr_grant_decoder
module tb_rr_grant_decoder;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [1:0] num;
    logic [1:0] prior;
    logic [2:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_num;
    logic       timeout;
    logic       err;

    int checks = 0;
    int errors = 0;

    rr_grant_decoder #(
        .REQCNT   (3),
        .REQWIDTH (2),
        .HOLD_MAX (4)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .num_i       (num),
        .prior_o     (prior),
        .gnt_o       (gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_num_o   (gnt_num),
        .timeout_o   (timeout),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        num   = 2'd0;
        step();
        step();
        chk("rst_gnt", gnt, 0);
        chk("rst_valid", gnt_valid, 0);
        chk("rst_num", gnt_num, 0);
        chk("rst_prior", prior, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;

        // idle with no requests
        step();
        chk("idle_gnt", gnt, 0);
        chk("idle_valid", gnt_valid, 0);

        // basic grant to 1 then release
        req = 3'b010; num = 2'd1;
        step();
        chk("basic_gnt", gnt, 3'b010);
        chk("basic_valid", gnt_valid, 1);
        chk("basic_num", gnt_num, 1);
        chk("basic_prior_hold", prior, 0);
        req = 3'b000;
        step();
        chk("basic_rel_gnt", gnt, 0);
        chk("basic_rel_valid", gnt_valid, 0);
        chk("basic_rel_prior", prior, 2);
        chk("basic_rel_timeout", timeout, 0);
        chk("basic_idle_num", gnt_num, 1);

        // timeout after four held cycles, then re-grant
        req = 3'b001; num = 2'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_hold_gnt", gnt, 3'b001);
            chk("to_hold_timeout", timeout, 0);
        end
        step();
        chk("to_gnt", gnt, 0);
        chk("to_pulse", timeout, 1);
        chk("to_prior", prior, 1);
        chk("to_valid", gnt_valid, 0);
        step();
        chk("to_regrant", gnt, 3'b001);
        chk("to_pulse_end", timeout, 0);
        req = 3'b000;
        step();
        chk("to_rel_prior", prior, 1);

        // wrap: holder 2 releases to pointer 0
        req = 3'b100; num = 2'd2;
        step();
        chk("wrap_gnt", gnt, 3'b100);
        chk("wrap_num", gnt_num, 2);
        req = 3'b000;
        step();
        chk("wrap_prior", prior, 0);
        req = 3'b111; num = 2'd0;
        step();
        chk("wrap_regrant", gnt, 3'b001);

        // non-holder requests ignored until timeout
        req = 3'b011; num = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nh_gnt", gnt, 3'b001);
            chk("nh_num", gnt_num, 0);
        end
        req = 3'b000;
        step();
        chk("nh_rel_gnt", gnt, 0);
        chk("nh_rel_prior", prior, 1);
        chk("nh_rel_timeout", timeout, 0);
        chk("nh_err", err, 0);

        // invalid index: request bit not set
        req = 3'b100; num = 2'd0;
        step();
        chk("inv_gnt", gnt, 0);
        chk("inv_valid", gnt_valid, 0);
        chk("inv_err", err, 1);
        req = 3'b000;
        step();
        chk("inv_err_sticky", err, 1);
        // out-of-range index
        req = 3'b111; num = 2'd3;
        step();
        chk("oor_gnt", gnt, 0);
        chk("oor_err", err, 1);

        // reset mid-grant
        req = 3'b010; num = 2'd1;
        step();
        chk("mr_gnt", gnt, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_gnt_async", gnt, 0);
        chk("mr_valid_async", gnt_valid, 0);
        chk("mr_prior_async", prior, 0);
        chk("mr_timeout_async", timeout, 0);
        chk("mr_err_async", err, 0);
        step();
        chk("mr_hold_gnt", gnt, 0);
        #2 rst_n = 1'b1;
        step();
        chk("mr_regrant", gnt, 3'b010);
        chk("mr_regrant_num", gnt_num, 1);
        chk("mr_timeout", timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
